// File: rtl/dram_pkg.sv
// Shared definitions for the byte-lane data RAM controller:
// memory op codes, FSM states and lane rotation/extension helpers.
package dram_pkg;

    localparam logic [2:0] OP_B  = 3'd0;
    localparam logic [2:0] OP_H  = 3'd1;
    localparam logic [2:0] OP_W  = 3'd2;
    localparam logic [2:0] OP_BU = 3'd4;
    localparam logic [2:0] OP_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RESP    = 2'd2
    } state_t;

    function automatic logic [3:0] op_base_be(input logic [2:0] op);
        case (op)
            OP_B, OP_BU: return 4'b0001;
            OP_H, OP_HU: return 4'b0011;
            OP_W:        return 4'b1111;
            default:     return 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] lane_rotate_be(
        input logic [3:0] be,
        input logic [1:0] ofs
    );
        logic [7:0] t;
        t = {be, be} << ofs;
        return t[7:4];
    endfunction

    // Rotate left by ofs bytes; rotating by -ofs undoes it.
    function automatic logic [31:0] lane_rotate_data(
        input logic [31:0] d,
        input logic [1:0]  ofs
    );
        logic [63:0] t;
        t = {d, d} << {ofs, 3'b000};
        return t[63:32];
    endfunction

    function automatic logic [31:0] load_extend(
        input logic [31:0] bytes,
        input logic [2:0]  op
    );
        case (op)
            OP_B:    return {{24{bytes[7]}}, bytes[7:0]};
            OP_H:    return {{16{bytes[15]}}, bytes[15:0]};
            OP_BU:   return {24'd0, bytes[7:0]};
            OP_HU:   return {16'd0, bytes[15:0]};
            default: return bytes;
        endcase
    endfunction

endpackage

// File: rtl/dram_lane_ctrl_lane.sv
// One 8-bit synchronous lane RAM with a RD_LAT-deep read register chain.
// Contents are never reset; only the read pipeline is.
module dram_lane
    import dram_pkg::*;
#(
    parameter int DEPTH  = 32768,
    parameter int RD_LAT = 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [7:0]    i_wdata,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem  [DEPTH];
    logic [7:0] r_pipe [RD_LAT];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < RD_LAT; k++) begin
                r_pipe[k] <= '0;
            end
        end else begin
            r_pipe[0] <= r_mem[i_addr];
            for (int k = 1; k < RD_LAT; k++) begin
                r_pipe[k] <= r_pipe[k-1];
            end
        end
    end

    assign o_rdata = r_pipe[RD_LAT-1];

endmodule

// File: rtl/dram_lane_ctrl.sv
// Byte-lane data RAM controller: one CPU load/store per request over
// four rotated 8-bit lane RAMs, with error reporting and read latency.
module dram_lane_ctrl
    import dram_pkg::*;
#(
    parameter int ADDR_W      = 17,
    parameter int RD_LAT      = 1,
    parameter int MISALIGN_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int WA_W  = ADDR_W - 2;
    localparam int DEPTH = 1 << WA_W;

    state_t      r_state;
    logic [1:0]  r_cnt;
    logic [1:0]  r_ofs;
    logic [2:0]  r_op;

    logic            w_accept;
    logic            w_op_bad;
    logic            w_oob;
    logic            w_misal;
    logic            w_bad;
    logic [3:0]      w_be;
    logic [WA_W-1:0] w_word;
    logic [WA_W-1:0] w_word_p1;
    logic [31:0]     w_wdata_rot;
    logic [31:0]     w_lane_q;
    logic [1:0]      w_unrot;
    logic [31:0]     w_load;
    logic [WA_W-1:0] w_lane_addr [4];
    logic [3:0]      w_lane_we;

    assign w_accept = (r_state == ST_IDLE) && req;

    assign w_op_bad = !(mem_op inside {OP_B, OP_H, OP_W, OP_BU, OP_HU})
                    || (we && mem_op[2]);
    assign w_oob    = |(addr >> ADDR_W);
    assign w_misal  = (MISALIGN_EN == 0)
                    && (((mem_op[1:0] == 2'd1) && addr[0])
                    || ((mem_op[1:0] == 2'd2) && (addr[1:0] != 2'd0)));
    assign w_bad    = w_op_bad || w_oob || w_misal;

    assign w_be        = lane_rotate_be(op_base_be(mem_op), addr[1:0]);
    assign w_word      = addr[ADDR_W-1:2];
    assign w_word_p1   = w_word + 1'b1;
    assign w_wdata_rot = lane_rotate_data(wdata, addr[1:0]);

    // Lanes below the start offset hold the bytes spilling into the next word.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign w_lane_addr[gi] = ((2'(gi) < addr[1:0]) && w_be[gi])
                               ? w_word_p1 : w_word;
        assign w_lane_we[gi]   = w_accept && we && !w_bad && w_be[gi];

        dram_lane #(
            .DEPTH  (DEPTH),
            .RD_LAT (RD_LAT)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .i_we    (w_lane_we[gi]),
            .i_addr  (w_lane_addr[gi]),
            .i_wdata (w_wdata_rot[8*gi +: 8]),
            .o_rdata (w_lane_q[8*gi +: 8])
        );
    end

    assign w_unrot = 2'd0 - r_ofs;
    assign w_load  = load_extend(lane_rotate_data(w_lane_q, w_unrot), r_op);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ofs   <= '0;
            r_op    <= '0;
            rdata   <= '0;
            ready   <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
            unique case (r_state)
                ST_IDLE: begin
                    if (req) begin
                        busy <= 1'b1;
                        if (w_bad) begin
                            err     <= 1'b1;
                            ready   <= 1'b1;
                            r_state <= ST_RESP;
                        end else if (we) begin
                            ready   <= 1'b1;
                            r_state <= ST_RESP;
                        end else begin
                            r_cnt   <= 2'(RD_LAT - 1);
                            r_ofs   <= addr[1:0];
                            r_op    <= mem_op;
                            r_state <= ST_RD_WAIT;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (r_cnt == 2'd0) begin
                        rdata   <= w_load;
                        ready   <= 1'b1;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                ST_RESP: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
